// File: rtl/xcel_mem_responder.sv
// rtl/xcel_mem_responder.sv - xcel read/write burst responder backed by a word-addressed sync RAM
module xcel_mem_responder #(
   parameter int AXI_AWIDTH = 32,
   parameter int AXI_DWIDTH = 32,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  xcel_read_request_valid,
   output logic                  xcel_read_request_ready,
   input  logic [AXI_AWIDTH-1:0] xcel_read_addr,
   input  logic [31:0]           xcel_read_len,
   input  logic [2:0]            xcel_read_size,
   input  logic [1:0]            xcel_read_burst,
   output logic [AXI_DWIDTH-1:0] xcel_read_data,
   output logic                  xcel_read_data_valid,
   input  logic                  xcel_read_data_ready,

   input  logic                  xcel_write_request_valid,
   output logic                  xcel_write_request_ready,
   input  logic [AXI_AWIDTH-1:0] xcel_write_addr,
   input  logic [31:0]           xcel_write_len,
   input  logic [2:0]            xcel_write_size,
   input  logic [1:0]            xcel_write_burst,
   input  logic [AXI_DWIDTH-1:0] xcel_write_data,
   input  logic                  xcel_write_data_valid,
   output logic                  xcel_write_data_ready,

   output logic                  idle
);

   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic { R_IDLE, R_BURST } r_state_e;
   typedef enum logic { W_IDLE, W_DATA  } w_state_e;

   logic [AXI_DWIDTH-1:0] mem_q [MEM_DEPTH];

   // Read channel state
   r_state_e              r_state_q, r_state_d;
   logic [AW-1:0]         r_idx_q, r_idx_d;
   logic                  r_fixed_q, r_fixed_d;
   logic [31:0]           r_left_q, r_left_d;
   logic                  r_setup_q, r_setup_d;
   logic                  r_pend_q, r_pend_d;
   logic                  r_valid_q, r_valid_d;
   logic [AXI_DWIDTH-1:0] r_data_q;
   logic                  r_issue;
   logic                  r_beat_hs;

   // Write channel state
   w_state_e              w_state_q, w_state_d;
   logic [AW-1:0]         w_idx_q, w_idx_d;
   logic                  w_fixed_q, w_fixed_d;
   logic [31:0]           w_left_q, w_left_d;
   logic                  w_beat_hs;

   logic                  unused_bits;
   assign unused_bits = ^{xcel_read_size, xcel_write_size,
                          xcel_read_addr[AXI_AWIDTH-1:AW+2], xcel_read_addr[1:0],
                          xcel_write_addr[AXI_AWIDTH-1:AW+2], xcel_write_addr[1:0]};

   assign r_issue   = (r_state_q == R_BURST) && r_pend_q && (!r_valid_q || xcel_read_data_ready);
   assign r_beat_hs = r_valid_q && xcel_read_data_ready;
   assign w_beat_hs = (w_state_q == W_DATA) && xcel_write_data_valid;

   // ---------------- read channel ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         r_idx_q   <= '0;
         r_fixed_q <= 1'b0;
         r_left_q  <= '0;
         r_setup_q <= 1'b0;
         r_pend_q  <= 1'b0;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_idx_q   <= r_idx_d;
         r_fixed_q <= r_fixed_d;
         r_left_q  <= r_left_d;
         r_setup_q <= r_setup_d;
         r_pend_q  <= r_pend_d;
         r_valid_q <= r_valid_d;
         if (r_issue) begin
            r_data_q <= mem_q[r_idx_q];
         end
      end
   end

   // r_left counts beats still to issue after the next one, so len=0xFFFFFFFF cannot overflow.
   always_comb begin
      r_state_d = r_state_q;
      r_idx_d   = r_idx_q;
      r_fixed_d = r_fixed_q;
      r_left_d  = r_left_q;
      r_setup_d = 1'b0;
      r_pend_d  = r_pend_q;
      r_valid_d = r_valid_q;
      case (r_state_q)
         R_IDLE: begin
            if (xcel_read_request_valid) begin
               r_state_d = R_BURST;
               r_idx_d   = xcel_read_addr[AW+1:2];
               r_fixed_d = (xcel_read_burst == 2'b00);
               r_left_d  = xcel_read_len;
               r_setup_d = 1'b1;
               r_pend_d  = 1'b0;
            end
         end
         R_BURST: begin
            // One setup cycle after acceptance fixes the two-edge first-beat latency.
            if (r_setup_q) begin
               r_pend_d = 1'b1;
            end
            if (r_issue) begin
               if (r_left_q == 32'd0) begin
                  r_pend_d = 1'b0;
               end else begin
                  r_left_d = r_left_q - 32'd1;
               end
               if (!r_fixed_q) begin
                  r_idx_d = r_idx_q + AW'(1);
               end
            end
            if (r_issue) begin
               r_valid_d = 1'b1;
            end else if (r_beat_hs) begin
               r_valid_d = 1'b0;
            end
            if (r_beat_hs && !r_pend_q && !r_setup_q) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      xcel_read_request_ready = (r_state_q == R_IDLE);
      xcel_read_data_valid    = r_valid_q;
      xcel_read_data          = r_data_q;
   end

   // ---------------- write channel ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_idx_q   <= '0;
         w_fixed_q <= 1'b0;
         w_left_q  <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_idx_q   <= w_idx_d;
         w_fixed_q <= w_fixed_d;
         w_left_q  <= w_left_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      w_idx_d   = w_idx_q;
      w_fixed_d = w_fixed_q;
      w_left_d  = w_left_q;
      case (w_state_q)
         W_IDLE: begin
            if (xcel_write_request_valid) begin
               w_state_d = W_DATA;
               w_idx_d   = xcel_write_addr[AW+1:2];
               w_fixed_d = (xcel_write_burst == 2'b00);
               w_left_d  = xcel_write_len;
            end
         end
         W_DATA: begin
            if (w_beat_hs) begin
               if (w_left_q == 32'd0) begin
                  w_state_d = W_IDLE;
               end else begin
                  w_left_d = w_left_q - 32'd1;
               end
               if (!w_fixed_q) begin
                  w_idx_d = w_idx_q + AW'(1);
               end
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      xcel_write_request_ready = (w_state_q == W_IDLE);
      xcel_write_data_ready    = (w_state_q == W_DATA);
   end

   // RAM contents survive reset; non-blocking write gives read-first on a same-edge collision.
   always_ff @(posedge clk) begin
      if (w_beat_hs) begin
         mem_q[w_idx_q] <= xcel_write_data;
      end
   end

   assign idle = (r_state_q == R_IDLE) && (w_state_q == W_IDLE) && !r_valid_q;

endmodule

// File: tb/tb_xcel_mem_responder.sv
// tb/tb_xcel_mem_responder.sv - directed table-driven bench for xcel_mem_responder
module tb_xcel_mem_responder;

   localparam logic [31:0] A0 = 32'h1111_00A0, A1 = 32'h2222_00A1,
                           A2 = 32'h3333_00A2, A3 = 32'h4444_00A3;
   localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB111_1111;
   localparam logic [31:0] C0 = 32'hC000_0000, C1 = 32'hC000_0001,
                           C2 = 32'hC000_0002, C3 = 32'hC000_0003;
   localparam logic [31:0] D0 = 32'hD000_0000, D1 = 32'hD000_0001,
                           D2 = 32'hD000_0002, D3 = 32'hD000_0003;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        xcel_read_request_valid = 1'b0;
   logic        xcel_read_request_ready;
   logic [31:0] xcel_read_addr = '0;
   logic [31:0] xcel_read_len = '0;
   logic [2:0]  xcel_read_size = 3'd2;
   logic [1:0]  xcel_read_burst = 2'b01;
   logic [31:0] xcel_read_data;
   logic        xcel_read_data_valid;
   logic        xcel_read_data_ready = 1'b0;
   logic        xcel_write_request_valid = 1'b0;
   logic        xcel_write_request_ready;
   logic [31:0] xcel_write_addr = '0;
   logic [31:0] xcel_write_len = '0;
   logic [2:0]  xcel_write_size = 3'd2;
   logic [1:0]  xcel_write_burst = 2'b01;
   logic [31:0] xcel_write_data = '0;
   logic        xcel_write_data_valid = 1'b0;
   logic        xcel_write_data_ready;
   logic        idle;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   xcel_mem_responder #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .MEM_DEPTH(1024)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .xcel_read_request_valid  (xcel_read_request_valid),
      .xcel_read_request_ready  (xcel_read_request_ready),
      .xcel_read_addr           (xcel_read_addr),
      .xcel_read_len            (xcel_read_len),
      .xcel_read_size           (xcel_read_size),
      .xcel_read_burst          (xcel_read_burst),
      .xcel_read_data           (xcel_read_data),
      .xcel_read_data_valid     (xcel_read_data_valid),
      .xcel_read_data_ready     (xcel_read_data_ready),
      .xcel_write_request_valid (xcel_write_request_valid),
      .xcel_write_request_ready (xcel_write_request_ready),
      .xcel_write_addr          (xcel_write_addr),
      .xcel_write_len           (xcel_write_len),
      .xcel_write_size          (xcel_write_size),
      .xcel_write_burst         (xcel_write_burst),
      .xcel_write_data          (xcel_write_data),
      .xcel_write_data_valid    (xcel_write_data_valid),
      .xcel_write_data_ready    (xcel_write_data_ready),
      .idle                     (idle)
   );

   typedef struct {
      string             name;
      logic [31:0]       addr;
      logic [31:0]       len;
      logic [1:0]        burst;
      int                mode;      // 0: ready held high, 1: ready toggles 1010...
      bit                chk_lat;
      logic [3:0][31:0]  exp;
   } rd_vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected handshake", name);
   endtask

   task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] len,
                           input logic [1:0] burst, input logic [3:0][31:0] data,
                           input bit chk_drop);
      logic hs;
      int   n;
      xcel_write_request_valid = 1'b1;
      xcel_write_addr  = addr;
      xcel_write_len   = len;
      xcel_write_burst = burst;
      n = 0;
      do begin
         @(negedge clk);
         hs = xcel_write_request_ready;
         @(posedge clk); #1;
         n++;
      end while (!hs && n < 50);
      xcel_write_request_valid = 1'b0;
      if (!hs) begin
         timeout({name, "_req"});
         return;
      end
      for (int i = 0; i <= int'(len); i++) begin
         xcel_write_data       = data[i];
         xcel_write_data_valid = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            hs = xcel_write_data_ready;
            @(posedge clk); #1;
            n++;
         end while (!hs && n < 50);
         if (!hs) begin
            xcel_write_data_valid = 1'b0;
            timeout({name, "_beat"});
            return;
         end
      end
      xcel_write_data_valid = 1'b0;
      if (chk_drop) begin
         @(negedge clk);
         chk({name, "_wready_drop"}, {31'd0, xcel_write_data_ready}, 32'd0);
         chk({name, "_wreq_ready"}, {31'd0, xcel_write_request_ready}, 32'd1);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_read(input rd_vec_t v);
      logic        hs;
      logic        stalled;
      logic [31:0] held;
      int          n;
      int          cyc;
      int          beats;
      xcel_read_request_valid = 1'b1;
      xcel_read_addr  = v.addr;
      xcel_read_len   = v.len;
      xcel_read_burst = v.burst;
      n = 0;
      do begin
         @(negedge clk);
         hs = xcel_read_request_ready;
         @(posedge clk); #1;
         n++;
      end while (!hs && n < 50);
      xcel_read_request_valid = 1'b0;
      if (!hs) begin
         timeout({v.name, "_req"});
         return;
      end
      cyc = 0;
      beats = 0;
      stalled = 1'b0;
      held = '0;
      while (beats <= int'(v.len) && cyc < 100) begin
         xcel_read_data_ready = (v.mode == 0) ? 1'b1 : (cyc % 2 == 0);
         @(negedge clk);
         if (v.chk_lat && cyc < 2)
            chk($sformatf("%s_lat_c%0d", v.name, cyc), {31'd0, xcel_read_data_valid}, 32'd0);
         if (v.chk_lat && cyc == 2)
            chk($sformatf("%s_lat_first", v.name), {31'd0, xcel_read_data_valid}, 32'd1);
         if (stalled) begin
            chk($sformatf("%s_stall_valid_c%0d", v.name, cyc), {31'd0, xcel_read_data_valid}, 32'd1);
            chk($sformatf("%s_stall_data_c%0d", v.name, cyc), xcel_read_data, held);
         end
         if (xcel_read_data_valid && xcel_read_data_ready) begin
            chk($sformatf("%s_beat%0d", v.name, beats), xcel_read_data, v.exp[beats]);
            beats++;
            stalled = 1'b0;
         end else if (xcel_read_data_valid) begin
            stalled = 1'b1;
            held = xcel_read_data;
         end
         @(posedge clk); #1;
         cyc++;
      end
      xcel_read_data_ready = 1'b0;
      if (beats <= int'(v.len)) begin
         timeout({v.name, "_beats"});
         return;
      end
      @(negedge clk);
      chk({v.name, "_end_valid"}, {31'd0, xcel_read_data_valid}, 32'd0);
      chk({v.name, "_end_rreq_ready"}, {31'd0, xcel_read_request_ready}, 32'd1);
      @(posedge clk); #1;
   endtask

   rd_vec_t rv [8];

   initial begin
      rv[0] = '{"incr4",      32'h0000_0010, 32'd3, 2'b01, 0, 1'b1, {A3, A2, A1, A0}};
      rv[1] = '{"incr4_bp",   32'h0000_0010, 32'd3, 2'b01, 1, 1'b1, {A3, A2, A1, A0}};
      rv[2] = '{"fixed3",     32'h0000_0014, 32'd2, 2'b00, 0, 1'b0, {32'h0, A1, A1, A1}};
      rv[3] = '{"single_bp",  32'h0000_0018, 32'd0, 2'b01, 1, 1'b0, {32'h0, 32'h0, 32'h0, A2}};
      rv[4] = '{"burst11",    32'h0000_0014, 32'd2, 2'b11, 1, 1'b0, {32'h0, A3, A2, A1}};
      rv[5] = '{"wrap2",      32'h0000_0FFC, 32'd1, 2'b01, 0, 1'b0, {32'h0, 32'h0, B1, B0}};
      rv[6] = '{"hiaddr",     32'h0000_2FFC, 32'd1, 2'b10, 1, 1'b0, {32'h0, 32'h0, B1, B0}};
      rv[7] = '{"concur_old", 32'h0000_0040, 32'd3, 2'b01, 0, 1'b0, {C3, C2, C1, C0}};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rvalid", {31'd0, xcel_read_data_valid}, 32'd0);
      chk("rst_rreq_ready", {31'd0, xcel_read_request_ready}, 32'd1);
      chk("rst_wreq_ready", {31'd0, xcel_write_request_ready}, 32'd1);
      chk("rst_wready", {31'd0, xcel_write_data_ready}, 32'd0);
      chk("rst_rdata", xcel_read_data, 32'd0);
      chk("rst_idle", {31'd0, idle}, 32'd1);

      // A write beat offered with no request must not be taken.
      @(posedge clk); #1;
      xcel_write_data = 32'hDEAD_BEEF;
      xcel_write_data_valid = 1'b1;
      @(negedge clk);
      chk("idle_wbeat_refused", {31'd0, xcel_write_data_ready}, 32'd0);
      @(posedge clk); #1;
      xcel_write_data_valid = 1'b0;

      do_write("w_incr4", 32'h0000_0010, 32'd3, 2'b01, {A3, A2, A1, A0}, 1'b1);
      do_write("w_wrap", 32'h0000_0FFC, 32'd1, 2'b01, {32'h0, 32'h0, B1, B0}, 1'b1);
      do_write("w_concur_init", 32'h0000_0040, 32'd3, 2'b01, {C3, C2, C1, C0}, 1'b0);

      for (int i = 0; i < 7; i++) begin
         do_read(rv[i]);
      end

      // Write starts one cycle behind the read so every read issue collides with a same-index write.
      fork
         do_read(rv[7]);
         begin
            @(posedge clk); #1;
            do_write("w_concur", 32'h0000_0040, 32'd3, 2'b01, {D3, D2, D1, D0}, 1'b0);
         end
      join
      do_read('{"concur_new", 32'h0000_0040, 32'd3, 2'b01, 0, 1'b0, {D3, D2, D1, D0}});

      // Reset in the middle of an 8-beat read while beat 2 is presented.
      xcel_read_request_valid = 1'b1;
      xcel_read_addr  = 32'h0000_0010;
      xcel_read_len   = 32'd7;
      xcel_read_burst = 2'b01;
      xcel_read_data_ready = 1'b1;
      @(posedge clk); #1;
      xcel_read_request_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_beat2_data", xcel_read_data, A2);
      chk("mid_busy", {31'd0, idle}, 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, xcel_read_data_valid}, 32'd0);
      chk("mid_rst_idle", {31'd0, idle}, 32'd1);
      chk("mid_rst_rreq_ready", {31'd0, xcel_read_request_ready}, 32'd1);
      chk("mid_rst_rdata", xcel_read_data, 32'd0);
      xcel_read_data_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      do_read(rv[0]);
      @(negedge clk);
      chk("final_idle", {31'd0, idle}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
